// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the 8-bit bus CPU datapath.
// Imported by the register file and its storage cells.
package cpu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int MAX_DEPTH = 16;

    function automatic int sel_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One bus register with parallel load and +/-1 step; a load beats a step.
// co is the carry (up) or borrow (down) out of the step.
module reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             step,
    input  logic             dn,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   stp;

    always_comb begin
        if (dn) stp = {1'b0, q_q} - (WIDTH+1)'(1);
        else    stp = {1'b0, q_q} + (WIDTH+1)'(1);
    end

    always_comb begin
        q_d = q_q;
        if (ld)        q_d = d;
        else if (step) q_d = stp[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q  = q_q;
    assign co = stp[WIDTH];

endmodule

// File: rtl/reg_file_bus.sv
// Multi-register file on the shared tri-state bus with two ALU operand ports,
// per-register up/down counting, zero/wrap status and a sticky bus-conflict flag.
module reg_file_bus
    import cpu_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = 4,
    localparam int SELW  = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic             rd_en,
    input  logic [SELW-1:0]  rd_sel,
    input  logic             cnt_en,
    input  logic [SELW-1:0]  cnt_sel,
    input  logic             cnt_dn,
    input  logic [SELW-1:0]  a_sel,
    input  logic [SELW-1:0]  b_sel,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             zero,
    output logic             wrap,
    output logic             err,
    inout  wire  [WIDTH-1:0] bus
);

    localparam logic [SELW:0] DEPTH_L = (SELW+1)'(DEPTH);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("reg_file_bus: DEPTH out of range");
    end

    logic [WIDTH-1:0] q [DEPTH];
    logic [DEPTH-1:0] co;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] step;
    logic             wr_ok;
    logic             cnt_ok;
    logic             cnt_exec;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_co;
    logic             zero_q, zero_d;
    logic             wrap_q;
    logic             err_q;

    // A bus conflict suppresses the write but leaves any count alone.
    assign wr_ok    = wr_en && !rd_en && ({1'b0, wr_sel} < DEPTH_L);
    assign cnt_ok   = cnt_en && ({1'b0, cnt_sel} < DEPTH_L);
    assign cnt_exec = cnt_ok && !(wr_ok && (wr_sel == cnt_sel));

    always_comb begin
        ld     = '0;
        step   = '0;
        a_out  = '0;
        b_out  = '0;
        rd_val = '0;
        cnt_q  = '0;
        cnt_co = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && wr_sel == SELW'(i))     ld[i]   = 1'b1;
            if (cnt_exec && cnt_sel == SELW'(i)) step[i] = 1'b1;
            if (a_sel == SELW'(i))   a_out  = q[i];
            if (b_sel == SELW'(i))   b_out  = q[i];
            if (rd_sel == SELW'(i))  rd_val = q[i];
            if (cnt_sel == SELW'(i)) begin
                cnt_q  = q[i];
                cnt_co = co[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk  (clk),
            .clr  (clr),
            .ld   (ld[g]),
            .d    (bus),
            .step (step[g]),
            .dn   (cnt_dn),
            .q    (q[g]),
            .co   (co[g])
        );
    end

    assign zero_d = cnt_dn ? (cnt_q == WIDTH'(1)) : cnt_co;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            zero_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (cnt_exec) begin
                zero_q <= zero_d;
                wrap_q <= cnt_co;
            end
            err_q <= err_q | (rd_en & wr_en);
        end
    end

    assign zero = zero_q;
    assign wrap = wrap_q;
    assign err  = err_q;
    assign bus  = rd_en ? rd_val : 'z;

endmodule

// File: tb/tb_reg_file_bus.sv
// Directed bench for reg_file_bus: vector table for the main datapath, hand
// sequences for conflict, async clear and an out-of-range DEPTH=3 instance.
module tb_reg_file_bus;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       wr_en, rd_en, cnt_en, cnt_dn;
    logic [1:0] wr_sel, rd_sel, cnt_sel, a_sel, b_sel;
    logic [7:0] a_out, b_out;
    logic       zero, wrap, err;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] bus;
    assign bus = drv_en ? drv_val : 8'hzz;

    reg_file_bus #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_sel(wr_sel), .rd_en(rd_en),
        .rd_sel(rd_sel), .cnt_en(cnt_en), .cnt_sel(cnt_sel), .cnt_dn(cnt_dn),
        .a_sel(a_sel), .b_sel(b_sel), .a_out(a_out), .b_out(b_out),
        .zero(zero), .wrap(wrap), .err(err), .bus(bus)
    );

    logic       wr_en3, rd_en3, cnt_en3, cnt_dn3;
    logic [1:0] wr_sel3, rd_sel3, cnt_sel3, a_sel3, b_sel3;
    logic [7:0] a_out3, b_out3;
    logic       zero3, wrap3, err3;
    logic       drv_en3;
    logic [7:0] drv_val3;
    wire  [7:0] bus3;
    assign bus3 = drv_en3 ? drv_val3 : 8'hzz;

    reg_file_bus #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .clr(clr), .wr_en(wr_en3), .wr_sel(wr_sel3), .rd_en(rd_en3),
        .rd_sel(rd_sel3), .cnt_en(cnt_en3), .cnt_sel(cnt_sel3), .cnt_dn(cnt_dn3),
        .a_sel(a_sel3), .b_sel(b_sel3), .a_out(a_out3), .b_out(b_out3),
        .zero(zero3), .wrap(wrap3), .err(err3), .bus(bus3)
    );

    typedef struct {
        logic       wr;
        logic [1:0] ws;
        logic [7:0] wd;
        logic       rd;
        logic [1:0] rs;
        logic       ce;
        logic [1:0] cs;
        logic       dn;
        logic [1:0] as;
        logic [1:0] bs;
        logic [7:0] e_bus;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic       e_z;
        logic       e_w;
        logic       e_e;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; cnt_en = 0; cnt_dn = 0; drv_en = 0;
        wr_sel = 0; rd_sel = 0; cnt_sel = 0; drv_val = 0;
    endtask

    initial begin
        tbl[0]  = '{0,0,8'h00, 0,0, 0,0,0, 0,1, 8'h00,8'h00,8'h00, 0,0,0};
        tbl[1]  = '{1,2,8'hA5, 0,0, 0,0,0, 2,2, 8'h00,8'hA5,8'hA5, 0,0,0};
        tbl[2]  = '{0,0,8'h00, 1,2, 0,0,0, 2,0, 8'hA5,8'hA5,8'h00, 0,0,0};
        tbl[3]  = '{1,1,8'hFF, 0,0, 0,0,0, 1,2, 8'h00,8'hFF,8'hA5, 0,0,0};
        tbl[4]  = '{0,0,8'h00, 0,0, 1,1,0, 1,2, 8'h00,8'h00,8'hA5, 1,1,0};
        tbl[5]  = '{0,0,8'h00, 0,0, 1,1,1, 1,2, 8'h00,8'hFF,8'hA5, 0,1,0};
        tbl[6]  = '{0,0,8'h00, 0,0, 1,1,1, 1,2, 8'h00,8'hFE,8'hA5, 0,0,0};
        tbl[7]  = '{1,0,8'h01, 0,0, 0,0,0, 0,1, 8'h00,8'h01,8'hFE, 0,0,0};
        tbl[8]  = '{0,0,8'h00, 0,0, 1,0,1, 0,1, 8'h00,8'h00,8'hFE, 1,0,0};
        tbl[9]  = '{1,3,8'h10, 0,0, 1,3,0, 3,0, 8'h00,8'h10,8'h00, 1,0,0};
        tbl[10] = '{1,3,8'h20, 0,0, 1,0,1, 3,0, 8'h00,8'h20,8'hFF, 0,1,0};
        tbl[11] = '{0,0,8'h00, 1,3, 0,0,0, 2,1, 8'h20,8'hA5,8'hFE, 0,1,0};

        idle();
        a_sel = 0; b_sel = 0;
        wr_en3 = 0; rd_en3 = 0; cnt_en3 = 0; cnt_dn3 = 0; drv_en3 = 0; drv_val3 = 0;
        wr_sel3 = 0; rd_sel3 = 0; cnt_sel3 = 0; a_sel3 = 0; b_sel3 = 0;
        repeat (2) step();
        clr = 0;
        step();

        for (int i = 0; i < 12; i++) begin
            wr_en = tbl[i].wr; wr_sel = tbl[i].ws; drv_val = tbl[i].wd;
            rd_en = tbl[i].rd; rd_sel = tbl[i].rs;
            cnt_en = tbl[i].ce; cnt_sel = tbl[i].cs; cnt_dn = tbl[i].dn;
            a_sel = tbl[i].as; b_sel = tbl[i].bs;
            drv_en = tbl[i].wr & ~tbl[i].rd;
            step();
            chk($sformatf("v%0d a_out", i), a_out, tbl[i].e_a);
            chk($sformatf("v%0d b_out", i), b_out, tbl[i].e_b);
            chk($sformatf("v%0d zero", i), {7'd0, zero}, {7'd0, tbl[i].e_z});
            chk($sformatf("v%0d wrap", i), {7'd0, wrap}, {7'd0, tbl[i].e_w});
            chk($sformatf("v%0d err", i), {7'd0, err}, {7'd0, tbl[i].e_e});
            if (tbl[i].rd) chk($sformatf("v%0d bus", i), bus, tbl[i].e_bus);
        end
        // regs now: r0=FF r1=FE r2=A5 r3=20, zero=0 wrap=1

        idle();
        wr_en = 1; wr_sel = 2; drv_val = 8'h3C; drv_en = 1; a_sel = 2;
        #1;
        chk("a_out before write edge", a_out, 8'hA5);
        step();
        chk("a_out after write edge", a_out, 8'h3C);

        idle();
        wr_en = 1; wr_sel = 0; drv_val = 8'h33; drv_en = 1;
        step();

        idle();
        rd_en = 1; rd_sel = 0; wr_en = 1; wr_sel = 1;
        cnt_en = 1; cnt_sel = 2; cnt_dn = 0; a_sel = 2; b_sel = 1;
        #1;
        chk("conflict bus pre-edge", bus, 8'h33);
        step();
        chk("conflict bus post-edge", bus, 8'h33);
        chk("conflict reg1 kept", b_out, 8'hFE);
        chk("conflict count ran", a_out, 8'h3D);
        chk("conflict err", {7'd0, err}, 8'h01);
        chk("conflict zero", {7'd0, zero}, 8'h00);
        chk("conflict wrap", {7'd0, wrap}, 8'h00);

        idle();
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("err sticky %0d", k), {7'd0, err}, 8'h01);
        end

        wr_en = 1; wr_sel = 3; drv_val = 8'hFF; drv_en = 1;
        step();
        idle();
        cnt_en = 1; cnt_sel = 3; cnt_dn = 0; a_sel = 3;
        step();
        chk("r3 wrap up value", a_out, 8'h00);
        chk("r3 wrap up zero", {7'd0, zero}, 8'h01);
        chk("r3 wrap up wrap", {7'd0, wrap}, 8'h01);

        idle();
        a_sel = 2; b_sel = 0;
        #2;
        clr = 1;
        #1;
        chk("clr a_out", a_out, 8'h00);
        chk("clr b_out", b_out, 8'h00);
        chk("clr zero", {7'd0, zero}, 8'h00);
        chk("clr wrap", {7'd0, wrap}, 8'h00);
        chk("clr err", {7'd0, err}, 8'h00);
        wr_en = 1; wr_sel = 2; drv_val = 8'h77; drv_en = 1;
        cnt_en = 1; cnt_sel = 0;
        step();
        clr = 0;
        idle();
        step();
        chk("write during clr lost", a_out, 8'h00);
        chk("count during clr lost", b_out, 8'h00);
        drv_val = 8'h5A; drv_en = 1;
        #1;
        chk("bus released when idle", bus, 8'h5A);
        idle();

        wr_en3 = 1; wr_sel3 = 3; drv_val3 = 8'h77; drv_en3 = 1;
        cnt_en3 = 1; cnt_sel3 = 3;
        step();
        wr_en3 = 0; drv_en3 = 0; cnt_en3 = 0;
        rd_en3 = 1; rd_sel3 = 3; a_sel3 = 3; b_sel3 = 0;
        #1;
        chk("d3 bus sel3", bus3, 8'h00);
        chk("d3 a_out sel3", a_out3, 8'h00);
        chk("d3 reg0 untouched", b_out3, 8'h00);
        chk("d3 err", {7'd0, err3}, 8'h00);
        chk("d3 zero", {7'd0, zero3}, 8'h00);
        chk("d3 wrap", {7'd0, wrap3}, 8'h00);
        rd_en3 = 0;
        for (int r = 0; r < 3; r++) begin
            a_sel3 = 2'(r);
            #1;
            chk($sformatf("d3 reg%0d clear", r), a_out3, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
